// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle MIPS-subset control path:
// opcode constants, datapath mux encodings, the 4-bit sequencer state
// enum and the bundled control word driven by multicycle_ctr.
package cpu_pkg;

    // Instruction opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALU operation requested from aluCtr
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] SRC_B_REG      = 2'b00;
    localparam logic [1:0] SRC_B_FOUR     = 2'b01;
    localparam logic [1:0] SRC_B_SEXT     = 2'b10;
    localparam logic [1:0] SRC_B_SEXT_SH2 = 2'b11;

    // Next-PC select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // Sequencer states; the codes are visible on state_out for LED debug
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_EXEC    = 4'd6,
        S_ALU_WB  = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11
    } state_e;

    // Every datapath control plus the end-of-instruction pulse
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

    // States that hold the shared memory port and wait on mem_ready
    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-state counter with bus timeout detection.
// Counts consecutive mem_ready=0 cycles while the sequencer sits in a
// memory state; timeout_o fires in the cycle the count has reached
// WAIT_LIMIT and memory is still not ready. WAIT_LIMIT=0 disables the
// timeout (the counter then saturates). Requires 2**CNT_W > WAIT_LIMIT.
module mem_wait_timer #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic mem_state_i,
    input  logic mem_ready_i,
    output logic timeout_o
);

    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(WAIT_LIMIT);
    localparam bit               LIMIT_EN = (WAIT_LIMIT != 0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Timeout: limit reached and memory still stalling this cycle
    always_comb begin
        timeout_o = LIMIT_EN && mem_state_i && !mem_ready_i && (cnt_q == LIMIT);
    end

    // Next count: advance on a stall, clear on completion, timeout or idle
    always_comb begin
        // NOTE: assigning a default first keeps this block purely combinational (no latch).
        cnt_d = '0;
        if (mem_state_i && !mem_ready_i && !timeout_o) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignment so every register samples pre-edge values.
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_ctr.sv
// Multicycle control sequencer for the MIPS-subset datapath.
// Moore FSM over FETCH/DECODE/execute/write-back states, with Mealy gating
// of ir_write, pc_write and instr_done on the memory ready handshake.
// Tracks memory wait states (mem_wait_timer) and raises sticky bus_error
// on timeout and sticky illegal_op on unknown opcodes.
// Build option: define MULTI_CTR_ADDI_EN to add addi (ADDI_EX/ADDI_WB);
// without it opcode 001000 is illegal.
module multicycle_ctr
    import cpu_pkg::*;
#(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic [5:0] op_code,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       bus_error,
    output logic [3:0] state_out
);

    state_e state_q, state_d;
    logic   illegal_op_q, illegal_op_d;
    logic   bus_error_q, bus_error_d;
    logic   timeout;
    ctrl_t  ctrl;

    mem_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT),
        .CNT_W      (CNT_W)
    ) u_wait_timer (
        .clk_i       (clock_in),
        .rst_i       (reset),
        .mem_state_i (is_mem_state(state_q)),
        .mem_ready_i (mem_ready),
        .timeout_o   (timeout)
    );

    // State and sticky error flags; reset aborts any instruction in flight
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q      <= S_FETCH;
            illegal_op_q <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            illegal_op_q <= illegal_op_d;
            bus_error_q  <= bus_error_d;
        end
    end

    // Next state: opcode dispatch, memory handshake and timeout recovery
    always_comb begin
        state_d      = state_q;
        illegal_op_d = illegal_op_q;
        bus_error_d  = bus_error_q;
        if (timeout) begin
            // Abandon the access; PC was not advanced so FETCH re-reads it
            state_d     = S_FETCH;
            bus_error_d = 1'b1;
        end else begin
            case (state_q)
                S_FETCH:   if (mem_ready) state_d = S_DECODE;
                S_DECODE: begin
                    case (op_code)
                        OP_RTYPE:     state_d = S_EXEC;
                        OP_LW, OP_SW: state_d = S_MEM_ADR;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_J:         state_d = S_JUMP;
`ifdef MULTI_CTR_ADDI_EN
                        OP_ADDI:      state_d = S_ADDI_EX;
`endif
                        default: begin
                            illegal_op_d = 1'b1;
                            state_d      = S_FETCH;
                        end
                    endcase
                end
                S_MEM_ADR: state_d = (op_code == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:  if (mem_ready) state_d = S_MEM_WB;
                S_MEM_WR:  if (mem_ready) state_d = S_FETCH;
                S_MEM_WB:  state_d = S_FETCH;
                S_EXEC:    state_d = S_ALU_WB;
                S_ALU_WB:  state_d = S_FETCH;
                S_BRANCH:  state_d = S_FETCH;
                S_JUMP:    state_d = S_FETCH;
`ifdef MULTI_CTR_ADDI_EN
                S_ADDI_EX: state_d = S_ADDI_WB;
                S_ADDI_WB: state_d = S_FETCH;
`endif
                default:   state_d = S_FETCH;
            endcase
        end
    end

    // Control outputs per state, gated by mem_ready, timeout and reset
    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.pc_source = PC_SRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRC_B_SEXT_SH2;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEM_ADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_SEXT;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_REG;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            S_ALU_WB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_SRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PC_SRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
`ifdef MULTI_CTR_ADDI_EN
            S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_SEXT;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_ADDI_WB: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.instr_done = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
        // A timed-out access must not commit any architectural state
        if (timeout) begin
            ctrl.ir_write  = 1'b0;
            ctrl.pc_write  = 1'b0;
            ctrl.reg_write = 1'b0;
        end
        // Reset suppresses every control immediately, not one edge later
        if (reset) begin
            ctrl = '0;
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign ir_write      = ctrl.ir_write;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign instr_done    = ctrl.instr_done;
    assign illegal_op    = illegal_op_q;
    assign bus_error     = bus_error_q;
    assign state_out     = state_q;

endmodule

// File: tb/tb_multicycle_ctr.sv
// Self-checking bench for multicycle_ctr. Each instruction is expanded
// into an expected per-cycle plan from its state path and the number of
// memory stall cycles in each memory phase; the bench drives mem_ready
// from that plan and compares state_out, all controls and the sticky flags.
// Honours MULTI_CTR_ADDI_EN the same way as the design.
module tb_multicycle_ctr;

    localparam int WAIT_LIMIT = 15;
    localparam int CNT_W      = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    logic       clock_in = 1'b0;
    logic       reset;
    logic [5:0] op_code;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, illegal_op, bus_error;
    logic [3:0] state_out;
    logic [16:0] act_ctrl;

    always #5 clock_in = ~clock_in;

    multicycle_ctr #(
        .WAIT_LIMIT (WAIT_LIMIT),
        .CNT_W      (CNT_W)
    ) dut (
        .clock_in      (clock_in),
        .reset         (reset),
        .op_code       (op_code),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ir_write      (ir_write),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op),
        .bus_error     (bus_error),
        .state_out     (state_out)
    );

    assign act_ctrl = {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
                       mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                       pc_source, instr_done};

    typedef struct {
        logic [3:0] st;
        logic       rdy;
        logic       tmo;
    } step_t;

    step_t plan[$];
    int    tests = 0;
    int    fails = 0;
    int    done_seen;
    logic  exp_illegal = 1'b0;
    logic  exp_bus     = 1'b0;

    // Expected control vector for a state code, straight from the state table
    function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic rdy);
        logic pcw, pcc, irw, iod, mr, mw, m2r, rd, rw, asa, done;
        logic [1:0] asb, aop, pcs;
        {pcw, pcc, irw, iod, mr, mw, m2r, rd, rw, asa, done} = '0;
        {asb, aop, pcs} = '0;
        case (st)
            4'd0:  begin mr = 1'b1; asb = 2'b01; irw = rdy; pcw = rdy; end
            4'd1:  asb = 2'b11;
            4'd2:  begin asa = 1'b1; asb = 2'b10; end
            4'd3:  begin mr = 1'b1; iod = 1'b1; end
            4'd4:  begin rw = 1'b1; m2r = 1'b1; done = 1'b1; end
            4'd5:  begin mw = 1'b1; iod = 1'b1; done = rdy; end
            4'd6:  begin asa = 1'b1; aop = 2'b10; end
            4'd7:  begin rd = 1'b1; rw = 1'b1; done = 1'b1; end
            4'd8:  begin asa = 1'b1; aop = 2'b01; pcc = 1'b1; pcs = 2'b01; done = 1'b1; end
            4'd9:  begin pcw = 1'b1; pcs = 2'b10; done = 1'b1; end
            4'd10: begin asa = 1'b1; asb = 2'b10; end
            4'd11: begin rw = 1'b1; done = 1'b1; end
            default: ;
        endcase
        return {pcw, pcc, irw, iod, mr, mw, m2r, rd, rw, asa, asb, aop, pcs, done};
    endfunction

    function automatic bit op_legal(input logic [5:0] op);
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
`ifdef MULTI_CTR_ADDI_EN
            OP_ADDI: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Non-memory state: mem_ready is randomised to show it is ignored
    task automatic push_fixed(input logic [3:0] st);
        logic r;
        r = 1'($urandom_range(0, 1));
        plan.push_back('{st: st, rdy: r, tmo: 1'b0});
    endtask

    // Memory phase with 'waits' stall cycles; too many stalls end in timeout
    task automatic push_mem(input logic [3:0] st, input int waits, output bit timed_out);
        timed_out = 1'b0;
        if (WAIT_LIMIT != 0 && waits > WAIT_LIMIT) begin
            for (int k = 0; k < WAIT_LIMIT; k++) plan.push_back('{st: st, rdy: 1'b0, tmo: 1'b0});
            plan.push_back('{st: st, rdy: 1'b0, tmo: 1'b1});
            timed_out = 1'b1;
        end else begin
            for (int k = 0; k < waits; k++) plan.push_back('{st: st, rdy: 1'b0, tmo: 1'b0});
            plan.push_back('{st: st, rdy: 1'b1, tmo: 1'b0});
        end
    endtask

    task automatic build_plan(input logic [5:0] op, input int fetch_waits, input int mem_waits);
        bit t;
        plan.delete();
        push_mem(4'd0, fetch_waits, t);
        if (t) return;
        push_fixed(4'd1);
        if (!op_legal(op)) return;
        case (op)
            OP_R:    begin push_fixed(4'd6); push_fixed(4'd7); end
            OP_LW:   begin push_fixed(4'd2); push_mem(4'd3, mem_waits, t); if (!t) push_fixed(4'd4); end
            OP_SW:   begin push_fixed(4'd2); push_mem(4'd5, mem_waits, t); end
            OP_BEQ:  push_fixed(4'd8);
            OP_J:    push_fixed(4'd9);
            OP_ADDI: begin push_fixed(4'd10); push_fixed(4'd11); end
            default: ;
        endcase
    endtask

    // Walk the plan one cycle at a time; called in the post-edge phase
    task automatic run_plan(input string tag, input logic [5:0] op, input int max_steps);
        logic [16:0] exp;
        done_seen = 0;
        for (int i = 0; i < plan.size() && i < max_steps; i++) begin
            op_code   = op;
            mem_ready = plan[i].rdy;
            @(negedge clock_in);
            tests++;
            if (state_out !== plan[i].st) begin
                fails++;
                $display("FAIL %s state step%0d: got %0d expected %0d", tag, i, state_out, plan[i].st);
            end
            exp = exp_ctrl(plan[i].st, plan[i].rdy);
            tests++;
            if (act_ctrl !== exp) begin
                fails++;
                $display("FAIL %s ctrl step%0d st%0d: got %b expected %b", tag, i, plan[i].st, act_ctrl, exp);
            end
            tests++;
            if ({illegal_op, bus_error} !== {exp_illegal, exp_bus}) begin
                fails++;
                $display("FAIL %s flags step%0d: got ill=%b bus=%b expected ill=%b bus=%b",
                         tag, i, illegal_op, bus_error, exp_illegal, exp_bus);
            end
            if (instr_done === 1'b1) done_seen++;
            if (plan[i].tmo) exp_bus = 1'b1;
            if (plan[i].st == 4'd1 && !op_legal(op)) exp_illegal = 1'b1;
            @(posedge clock_in);
            #1;
        end
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        mem_ready = 1'b1;
        @(posedge clock_in);
        #1;
        reset       = 1'b0;
        exp_illegal = 1'b0;
        exp_bus     = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        mem_ready = 1'b1;
        op_code   = 6'($urandom);
        repeat (2) @(posedge clock_in);
        #1;
        tests++;
        if (state_out !== 4'd0) begin
            fails++; $display("FAIL reset_state: got %0d expected 0", state_out);
        end
        tests++;
        if (act_ctrl !== 17'd0) begin
            fails++; $display("FAIL reset_ctrl: got %b expected all zero", act_ctrl);
        end
        tests++;
        if ({illegal_op, bus_error} !== 2'b00) begin
            fails++; $display("FAIL reset_flags: got %b expected 00", {illegal_op, bus_error});
        end
        reset       = 1'b0;
        exp_illegal = 1'b0;
        exp_bus     = 1'b0;
    endtask

    task automatic test_rtype();
        build_plan(OP_R, 0, 0);
        run_plan("rtype", OP_R, 1000);
        tests++;
        if (done_seen !== 1) begin
            fails++; $display("FAIL rtype_done: got %0d pulses expected 1", done_seen);
        end
        tests++;
        if (state_out !== 4'd0) begin
            fails++; $display("FAIL rtype_end: got %0d expected 0", state_out);
        end
    endtask

    task automatic test_lw_wait();
        build_plan(OP_LW, 0, 3);
        run_plan("lw_wait", OP_LW, 1000);
        tests++;
        if (done_seen !== 1 || bus_error !== 1'b0) begin
            fails++; $display("FAIL lw_wait_end: got done=%0d bus=%b expected done=1 bus=0", done_seen, bus_error);
        end
    endtask

    task automatic test_sw_timeout();
        build_plan(OP_SW, 0, 100);
        run_plan("sw_tmo", OP_SW, 1000);
        tests++;
        if (done_seen !== 0 || state_out !== 4'd0 || bus_error !== 1'b1) begin
            fails++;
            $display("FAIL sw_tmo_end: got done=%0d st=%0d bus=%b expected done=0 st=0 bus=1",
                     done_seen, state_out, bus_error);
        end
        mem_ready = 1'b0;
        #1;
        tests++;
        if (mem_write !== 1'b0 || mem_read !== 1'b1) begin
            fails++; $display("FAIL sw_tmo_refetch: got mw=%b mr=%b expected mw=0 mr=1", mem_write, mem_read);
        end
    endtask

    task automatic test_branch_jump();
        build_plan(OP_BEQ, 1, 0);
        run_plan("beq", OP_BEQ, 1000);
        build_plan(OP_J, 2, 0);
        run_plan("jump", OP_J, 1000);
        tests++;
        if (done_seen !== 1) begin
            fails++; $display("FAIL jump_done: got %0d pulses expected 1", done_seen);
        end
    endtask

    task automatic test_illegal();
        build_plan(6'b111111, 0, 0);
        run_plan("illegal", 6'b111111, 1000);
        tests++;
        if (illegal_op !== 1'b1 || state_out !== 4'd0 || done_seen !== 0) begin
            fails++;
            $display("FAIL illegal_set: got ill=%b st=%0d done=%0d expected ill=1 st=0 done=0",
                     illegal_op, state_out, done_seen);
        end
        build_plan(OP_R, 0, 0);
        run_plan("after_illegal", OP_R, 1000);
        tests++;
        if (illegal_op !== 1'b1) begin
            fails++; $display("FAIL illegal_sticky: got %b expected 1", illegal_op);
        end
    endtask

    task automatic test_addi();
        logic exp_ill;
`ifdef MULTI_CTR_ADDI_EN
        exp_ill = 1'b0;
`else
        exp_ill = 1'b1;
`endif
        apply_reset();
        build_plan(OP_ADDI, 1, 0);
        run_plan("addi", OP_ADDI, 1000);
        tests++;
        if (illegal_op !== exp_ill || state_out !== 4'd0) begin
            fails++; $display("FAIL addi_end: got ill=%b st=%0d expected ill=%b st=0", illegal_op, state_out, exp_ill);
        end
    endtask

    task automatic test_reset_mid();
        build_plan(OP_LW, 0, 10);
        run_plan("lw_abort", OP_LW, 5);
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        tests++;
        if (state_out !== 4'd3 || act_ctrl !== 17'd0) begin
            fails++; $display("FAIL abort_gate: got st=%0d ctrl=%b expected st=3 ctrl=0", state_out, act_ctrl);
        end
        @(posedge clock_in);
        #1;
        reset       = 1'b0;
        mem_ready   = 1'b0;
        exp_illegal = 1'b0;
        exp_bus     = 1'b0;
        #1;
        tests++;
        if (state_out !== 4'd0 || {reg_write, pc_write, ir_write, mem_write} !== 4'b0000) begin
            fails++;
            $display("FAIL abort_next: got st=%0d writes=%b expected st=0 writes=0000",
                     state_out, {reg_write, pc_write, ir_write, mem_write});
        end
        // A stale wait count from the aborted read would time this fetch out
        build_plan(OP_R, WAIT_LIMIT, 0);
        run_plan("post_abort", OP_R, 1000);
        tests++;
        if (bus_error !== 1'b0 || done_seen !== 1) begin
            fails++; $display("FAIL post_abort: got bus=%b done=%0d expected bus=0 done=1", bus_error, done_seen);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [7];
        logic [5:0] op;
        int         fw, mw;
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, 6'b000000};
        apply_reset();
        for (int n = 0; n < 60; n++) begin
            op = ops[$urandom_range(0, 6)];
            if (n % 7 == 6) op = 6'($urandom);
            fw = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 4);
            mw = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 5);
            build_plan(op, fw, mw);
            run_plan("random", op, 1000);
        end
    endtask

    initial begin
        reset     = 1'b1;
        op_code   = 6'd0;
        mem_ready = 1'b0;
        @(posedge clock_in);
        #1;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw_timeout();
        test_branch_jump();
        test_illegal();
        test_addi();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
